// File: rtl/pwm_halfbridge_setpoint_sequencer_if.sv
// Setpoint request and tick-number bundle between an upstream controller and the
// half-bridge setpoint sequencer.
// Ports: request_valid/request_ready/duty_cycle/dead_time (request handshake),
//        load_enable, four tick numbers and two per-side disables (generator side).
interface pwm_halfbridge_setpoint_sequencer_if #(
  parameter int bitwidth = 8
);
  logic                request_valid;
  logic                request_ready;
  logic [bitwidth-1:0] duty_cycle;
  logic [bitwidth-1:0] dead_time;
  logic                load_enable;
  logic [bitwidth-1:0] tick_number_rising_edge_highside;
  logic [bitwidth-1:0] tick_number_falling_edge_highside;
  logic [bitwidth-1:0] tick_number_rising_edge_lowside;
  logic [bitwidth-1:0] tick_number_falling_edge_lowside;
  logic                disable_highside_output;
  logic                disable_lowside_output;

  // Upstream controller: offers setpoints and observes the generator-side outputs.
  modport master (
    output request_valid, duty_cycle, dead_time,
    input  request_ready, load_enable,
           tick_number_rising_edge_highside, tick_number_falling_edge_highside,
           tick_number_rising_edge_lowside, tick_number_falling_edge_lowside,
           disable_highside_output, disable_lowside_output
  );

  // Sequencer: accepts setpoints and drives the generator-side outputs.
  modport slave (
    input  request_valid, duty_cycle, dead_time,
    output request_ready, load_enable,
           tick_number_rising_edge_highside, tick_number_falling_edge_highside,
           tick_number_rising_edge_lowside, tick_number_falling_edge_lowside,
           disable_highside_output, disable_lowside_output
  );
endinterface

// File: rtl/pwm_halfbridge_setpoint_sequencer.sv
// Purpose: turn a duty/dead-time request into four dead-time-separated edge ticks,
//          saturating either side to "off", and load them on the next counter overflow.
// Latency: accept N, compute N+1, ticks valid in ARMED at N+2, load_enable the cycle
//          after the first overflow rising edge seen in ARMED.
// Backpressure: request_ready is high only in IDLE; one request in flight at a time.
// Ports: clock, reset (sync, active-high), enable (global output enable),
//        counter_overflow (PWM counter level), bus (slave side of the setpoint interface).
module pwm_halfbridge_setpoint_sequencer #(
  parameter int bitwidth      = 8,
  parameter int max_dead_time = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic counter_overflow,
  pwm_halfbridge_setpoint_sequencer_if.slave bus
);

  localparam logic [bitwidth-1:0] max_dt_clamp = max_dead_time[bitwidth-1:0];

  typedef enum logic [1:0] {IDLE, COMPUTE, ARMED, LOAD} state_t;

  state_t              state;
  logic                ovf_prev;
  logic                ovf_edge;
  logic [bitwidth-1:0] duty_q;
  logic [bitwidth-1:0] dt_req_q;
  logic                hs_off_pending;
  logic                ls_off_pending;
  logic                hs_off_latched;
  logic                ls_off_latched;

  // Candidate computation on the captured request. The sum carries one extra bit
  // so that a low-side rising tick past the end of the period is detectable.
  logic [bitwidth-1:0] dt_clamped;
  logic [bitwidth:0]   ls_rise_sum;
  logic                hs_off_c;
  logic                ls_off_c;

  assign ovf_edge    = counter_overflow & ~ovf_prev;
  assign dt_clamped  = (dt_req_q > max_dt_clamp) ? max_dt_clamp : dt_req_q;
  assign ls_rise_sum = {1'b0, duty_q} + {1'b0, dt_clamped};
  // High side has no on-window when its falling tick does not exceed its rising tick.
  assign hs_off_c    = (duty_q <= dt_clamped);
  // Low side would have to turn on at or after the period wraps.
  assign ls_off_c    = ls_rise_sum[bitwidth];

  always_ff @(posedge clock) begin
    if (reset) begin
      state                                 <= IDLE;
      ovf_prev                              <= 1'b0;
      duty_q                                <= '0;
      dt_req_q                              <= '0;
      hs_off_pending                        <= 1'b0;
      ls_off_pending                        <= 1'b0;
      hs_off_latched                        <= 1'b0;
      ls_off_latched                        <= 1'b0;
      bus.request_ready                     <= 1'b1;
      bus.load_enable                       <= 1'b0;
      bus.tick_number_rising_edge_highside  <= '0;
      bus.tick_number_falling_edge_highside <= '0;
      bus.tick_number_rising_edge_lowside   <= '0;
      bus.tick_number_falling_edge_lowside  <= '0;
      bus.disable_highside_output           <= 1'b1;
      bus.disable_lowside_output            <= 1'b1;
    end else begin
      ovf_prev        <= counter_overflow;
      bus.load_enable <= 1'b0;
      // Enable gating follows every cycle; overridden below when new flags are adopted.
      bus.disable_highside_output <= ~enable | hs_off_latched;
      bus.disable_lowside_output  <= ~enable | ls_off_latched;

      case (state)
        IDLE: begin
          // An overflow edge coinciding with acceptance is deliberately not acted on:
          // the tick numbers are not computed yet.
          if (bus.request_valid) begin
            duty_q            <= bus.duty_cycle;
            dt_req_q          <= bus.dead_time;
            bus.request_ready <= 1'b0;
            state             <= COMPUTE;
          end
        end

        COMPUTE: begin
          bus.tick_number_rising_edge_highside  <= hs_off_c ? '0 : dt_clamped;
          bus.tick_number_falling_edge_highside <= hs_off_c ? '0 : duty_q;
          bus.tick_number_rising_edge_lowside   <= ls_off_c ? '0 : ls_rise_sum[bitwidth-1:0];
          bus.tick_number_falling_edge_lowside  <= '0;
          hs_off_pending                        <= hs_off_c;
          ls_off_pending                        <= ls_off_c;
          state                                 <= ARMED;
        end

        ARMED: begin
          if (ovf_edge) begin
            // Flags and disables switch together with the load strobe so the
            // generator never sees new ticks with stale side enables.
            bus.load_enable             <= 1'b1;
            hs_off_latched              <= hs_off_pending;
            ls_off_latched              <= ls_off_pending;
            bus.disable_highside_output <= ~enable | hs_off_pending;
            bus.disable_lowside_output  <= ~enable | ls_off_pending;
            state                       <= LOAD;
          end
        end

        LOAD: begin
          bus.request_ready <= 1'b1;
          state             <= IDLE;
        end

        default: begin
          bus.request_ready <= 1'b1;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_halfbridge_setpoint_sequencer.md
Name: pwm_halfbridge_setpoint_sequencer

Overview:
Upstream stage of the half-bridge gate signal generator. Accepts a duty-cycle and dead-time request over a valid/ready handshake, and derives the four edge tick numbers with dead-time insertion and saturation. It presents them stable and issues a single-cycle load_enable aligned to the next PWM counter overflow. It also drives the generator's per-side disable inputs.

Parameters:
bitwidth, 8, width of counter, duty, dead time and all tick numbers; PWM period is 2^bitwidth ticks
max_dead_time, 15, upper clamp applied to requested dead time (must be < 2^bitwidth)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
enable  input  1  global output enable; low forces both disable outputs high
request_valid  input  1  new setpoint offered
request_ready  output  1  sequencer can accept a setpoint
duty_cycle  input  bitwidth  requested high-side falling tick
dead_time  input  bitwidth  requested dead time in ticks
counter_overflow  input  1  level from PWM counter; its rising edge marks the period start
load_enable  output  1  one-cycle strobe to adopt tick numbers
tick_number_rising_edge_highside  output  bitwidth  HS on tick
tick_number_falling_edge_highside  output  bitwidth  HS off tick
tick_number_rising_edge_lowside  output  bitwidth  LS on tick
tick_number_falling_edge_lowside  output  bitwidth  LS off tick
disable_highside_output  output  1  high = HS held low
disable_lowside_output  output  1  high = LS held low

Behaviour:
- Reset values: request_ready=1, load_enable=0, all tick outputs 0, both disable outputs 1, state IDLE, overflow edge register 0.
- Overflow edge: ovf_prev registered each cycle. ovf_edge = counter_overflow & ~ovf_prev.
- FSM states: IDLE, COMPUTE, ARMED, LOAD.
  - IDLE: request_ready=1. If request_valid, capture duty_cycle and dead_time and go to COMPUTE. request_ready=0 in all other states.
  - COMPUTE (1 cycle): dt = min(dead_time, max_dead_time). Arithmetic is in bitwidth+1 bits. Register the candidates and go to ARMED.
    - HS_rise=dt, HS_fall=duty.
    - LS_rise=duty+dt, LS_fall=0.
    - hs_off = (duty <= dt).
    - ls_off = (duty+dt >= 2^bitwidth).
    - If hs_off: HS_rise=HS_fall=0.
    - If ls_off: LS_rise=LS_fall=0.
  - ARMED: tick outputs already hold the new values (updated on ARMED entry) and stay constant. On ovf_edge, go to LOAD. An ovf_edge during IDLE or COMPUTE is ignored; the sequencer waits for the next one.
  - LOAD (1 cycle): load_enable=1. Pending disable flags are transferred to the disable outputs in this cycle, then return to IDLE.
- Latency: handshake cycle N → COMPUTE N+1 → ARMED N+2 → LOAD the cycle after the first ovf_edge seen in ARMED.
- load_enable is asserted exactly one cycle per accepted request, never otherwise.
- Tick outputs change only on ARMED entry and never while load_enable=1.
- Disable outputs: disable_x = ~enable | x_off_latched, where x_off_latched updates only in LOAD. Deassertion of enable takes effect the next cycle regardless of state.
- Dead time: both gaps (HS_fall→LS_rise and LS_fall→HS_rise) equal the clamped dt.
- reset mid-operation (any state) discards the pending request: no load_enable, outputs return to reset values.
- Simultaneous request_valid and ovf_edge in IDLE: the request is accepted; this edge does not trigger a load.

Test Plan:
- Reset, then enable=1, duty=100, dt=10 accepted; pulse counter_overflow → HS 10/100, LS 110/0, one load_enable cycle after the edge, both disables 0.
- dead_time=40, max_dead_time=15 → dt clamped: HS_rise=15, LS_rise=duty+15.
- duty=8, dt=10 → hs_off: HS ticks 0/0, disable_highside_output=1 after LOAD; LS 18/0 with disable_lowside_output=0.
- duty=250, dt=10 (bitwidth 8) → sum 260 ≥ 256: LS ticks 0/0, disable_lowside_output=1; HS 10/250 enabled.
- Overflow edge arrives in COMPUTE → no load; the next edge in ARMED yields load_enable; request_ready stays 0 until back in IDLE.
- reset asserted in ARMED → no load_enable, ticks 0, disables 1, request_ready=1 the next cycle; enable dropped mid-ARMED → both disables 1 the next cycle.
